// File: rtl/etherneco_synctimer_trigger_if.sv
// Wishbone slave bus bundle for the sync-timer trigger unit.
//   s_wb_adr_i : word address
//   s_wb_dat_i : write data
//   s_wb_sel_i : byte selects for writes
//   s_wb_we_i  : write enable
//   s_wb_stb_i : strobe (one access per strobed cycle)
//   s_wb_dat_o : read data, combinational from the address
//   s_wb_ack_o : acknowledge, zero-wait (follows strobe)
interface etherneco_synctimer_trigger_if #(
  parameter int WB_ADR_WIDTH = 16,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH/8
);
  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
  logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
  logic                    s_wb_we_i;
  logic                    s_wb_stb_i;
  logic                    s_wb_ack_o;

  modport master (
    output s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
    input  s_wb_dat_o, s_wb_ack_o
  );

  modport slave (
    input  s_wb_adr_i, s_wb_dat_i, s_wb_sel_i, s_wb_we_i, s_wb_stb_i,
    output s_wb_dat_o, s_wb_ack_o
  );
endinterface

// File: rtl/etherneco_synctimer_trigger.sv
// Multi-channel time-compare / trigger unit on the synchronised slave timer.
// Each channel compares current_time with a 64-bit target and emits a
// one-cycle trigger pulse, one-shot or periodic, with a sticky fired flag,
// a fire counter and a level interrupt.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   s_wb         : Wishbone slave bus (zero-wait, ack = stb)
//   current_time : synchronised time from the slave timer core
//   trig         : per-channel one-cycle trigger pulse (registered)
//   irq          : level interrupt, |(fired & irq_en), registered
module etherneco_synctimer_trigger #(
  parameter int          NUM_CH       = 4,
  parameter int          TIMER_WIDTH  = 64,
  parameter int          WB_ADR_WIDTH = 16,
  parameter int          WB_DAT_WIDTH = 32,
  parameter int          WB_SEL_WIDTH = WB_DAT_WIDTH/8,
  parameter logic [31:0] CORE_ID      = 32'hffff1123
) (
  input  logic                        clk,
  input  logic                        rst,
  etherneco_synctimer_trigger_if.slave s_wb,
  input  logic [TIMER_WIDTH-1:0]      current_time,
  output logic [NUM_CH-1:0]           trig,
  output logic                        irq
);

  localparam int HI_W = TIMER_WIDTH - 32;

  localparam logic [WB_ADR_WIDTH-1:0] A_CORE_ID = WB_ADR_WIDTH'(16'h00);
  localparam logic [WB_ADR_WIDTH-1:0] A_CONFIG  = WB_ADR_WIDTH'(16'h01);
  localparam logic [WB_ADR_WIDTH-1:0] A_TIME_LO = WB_ADR_WIDTH'(16'h08);
  localparam logic [WB_ADR_WIDTH-1:0] A_TIME_HI = WB_ADR_WIDTH'(16'h09);

  logic [WB_ADR_WIDTH-1:0] w_adr;
  logic [WB_DAT_WIDTH-1:0] w_dat_i;
  logic [WB_SEL_WIDTH-1:0] w_sel;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_ch_region;
  logic [2:0]              w_ch;
  logic [2:0]              w_off;
  logic [WB_DAT_WIDTH-1:0] w_rdata;
  logic [NUM_CH-1:0]       w_hit;
  logic [TIMER_WIDTH-1:0]  w_diff;

  logic [NUM_CH-1:0]       r_enable;
  logic [NUM_CH-1:0]       r_periodic;
  logic [NUM_CH-1:0]       r_irq_en;
  logic [NUM_CH-1:0]       r_fired;
  logic [NUM_CH-1:0]       r_trig;
  logic [TIMER_WIDTH-1:0]  r_cmp       [NUM_CH];
  logic [TIMER_WIDTH-1:0]  r_per       [NUM_CH];
  logic [31:0]             r_cmp_stage [NUM_CH];
  logic [31:0]             r_per_stage [NUM_CH];
  logic [31:0]             r_fire_cnt  [NUM_CH];
  logic [HI_W-1:0]         r_time_snap;
  logic                    r_irq;

  function automatic logic [31:0] f_merge(input logic [31:0]             old,
                                          input logic [31:0]             dat,
                                          input logic [WB_SEL_WIDTH-1:0] sel);
    logic [31:0] m;
    m = old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) m[8*b +: 8] = dat[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [HI_W-1:0] f_merge_hi(input logic [HI_W-1:0]         old,
                                                 input logic [31:0]             dat,
                                                 input logic [WB_SEL_WIDTH-1:0] sel);
    logic [31:0] m;
    m = f_merge(32'(old), dat, sel);
    return m[HI_W-1:0];
  endfunction

  assign w_adr       = s_wb.s_wb_adr_i;
  assign w_dat_i     = s_wb.s_wb_dat_i;
  assign w_sel       = s_wb.s_wb_sel_i;
  assign w_wr        = s_wb.s_wb_stb_i &  s_wb.s_wb_we_i;
  assign w_rd        = s_wb.s_wb_stb_i & ~s_wb.s_wb_we_i;
  // Channel window 0x40..0x7F: eight words per channel.
  assign w_ch_region = (w_adr[WB_ADR_WIDTH-1:6] == (WB_ADR_WIDTH-6)'(1));
  assign w_ch        = w_adr[5:3];
  assign w_off       = w_adr[2:0];

  assign s_wb.s_wb_ack_o = s_wb.s_wb_stb_i;
  assign s_wb.s_wb_dat_o = w_rdata;
  assign trig            = r_trig;
  assign irq             = r_irq;

  // Wrap-safe compare: fire once the signed distance current_time - cmp is >= 0.
  always_comb begin
    w_hit  = '0;
    w_diff = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_diff   = current_time - r_cmp[i];
      w_hit[i] = r_enable[i] & ~w_diff[TIMER_WIDTH-1];
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_adr == A_CORE_ID) begin
      w_rdata = CORE_ID;
    end else if (w_adr == A_CONFIG) begin
      w_rdata = {16'd0, 8'(TIMER_WIDTH), 8'(NUM_CH)};
    end else if (w_adr == A_TIME_LO) begin
      w_rdata = current_time[31:0];
    end else if (w_adr == A_TIME_HI) begin
      w_rdata = 32'(r_time_snap);
    end else if (w_ch_region) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (w_ch == 3'(i)) begin
          case (w_off)
            3'd0:    w_rdata = {29'd0, r_irq_en[i], r_periodic[i], r_enable[i]};
            3'd1:    w_rdata = r_cmp[i][31:0];
            3'd2:    w_rdata = 32'(r_cmp[i][TIMER_WIDTH-1:32]);
            3'd3:    w_rdata = r_per[i][31:0];
            3'd4:    w_rdata = 32'(r_per[i][TIMER_WIDTH-1:32]);
            3'd5:    w_rdata = {31'd0, r_fired[i]};
            3'd6:    w_rdata = r_fire_cnt[i];
            default: w_rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable    <= '0;
      r_periodic  <= '0;
      r_irq_en    <= '0;
      r_fired     <= '0;
      r_trig      <= '0;
      r_irq       <= 1'b0;
      r_time_snap <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_cmp[i]       <= '0;
        r_per[i]       <= '0;
        r_cmp_stage[i] <= '0;
        r_per_stage[i] <= '0;
        r_fire_cnt[i]  <= '0;
      end
    end else begin
      r_trig <= w_hit;
      r_irq  <= |(r_fired & r_irq_en);

      // Reading the low time word freezes the upper bits for the following high read.
      if (w_rd && (w_adr == A_TIME_LO)) r_time_snap <= current_time[TIMER_WIDTH-1:32];

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // Fire side effects are assigned first so a same-cycle bus write to
        // CTRL or CMP_HI overrides them; the STATUS clear is suppressed instead.
        if (w_hit[i]) begin
          r_fired[i]    <= 1'b1;
          r_fire_cnt[i] <= r_fire_cnt[i] + 32'd1;
          if (r_periodic[i] && (r_per[i] != '0)) r_cmp[i]    <= r_cmp[i] + r_per[i];
          else                                    r_enable[i] <= 1'b0;
        end

        if (w_wr && w_ch_region && (w_ch == 3'(i))) begin
          case (w_off)
            3'd0: begin
              if (w_sel[0]) begin
                r_enable[i]   <= w_dat_i[0];
                r_periodic[i] <= w_dat_i[1];
                r_irq_en[i]   <= w_dat_i[2];
              end
            end
            3'd1: r_cmp_stage[i] <= f_merge(r_cmp_stage[i], w_dat_i, w_sel);
            3'd2: r_cmp[i] <= {f_merge_hi(r_cmp[i][TIMER_WIDTH-1:32], w_dat_i, w_sel),
                               r_cmp_stage[i]};
            3'd3: r_per_stage[i] <= f_merge(r_per_stage[i], w_dat_i, w_sel);
            3'd4: r_per[i] <= {f_merge_hi(r_per[i][TIMER_WIDTH-1:32], w_dat_i, w_sel),
                               r_per_stage[i]};
            3'd5: begin
              if (w_sel[0] && w_dat_i[0] && !w_hit[i]) r_fired[i] <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
